// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 controller datapath.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_rx_state_t;

  localparam int unsigned PS2_DATA_BITS  = 8;
  localparam logic        PS2_IDLE_LEVEL = 1'b1;

  // Odd parity: the data bits plus the parity bit must hold an odd number of ones.
  function automatic logic ps2_odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                             input logic                     par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Multi-stage synchroniser for the PS/2 clock and data pins, with a
// registered falling-edge strobe on the clock line and data aligned to it.
module ps2_sync_edge
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic fall_o,
  output logic data_o
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   fall_q;
  logic                   data_q;

  // Data is delayed one extra stage so it lines up with the registered strobe.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      clk_sync_q  <= {SYNC_STAGES{PS2_IDLE_LEVEL}};
      data_sync_q <= {SYNC_STAGES{PS2_IDLE_LEVEL}};
      clk_prev_q  <= PS2_IDLE_LEVEL;
      fall_q      <= 1'b0;
      data_q      <= PS2_IDLE_LEVEL;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
      fall_q      <= clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
      data_q      <= data_sync_q[SYNC_STAGES-1];
    end
  end

  assign fall_o = fall_q;
  assign data_o = data_q;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: deserialises 11-bit frames, checks
// framing and odd parity, and aborts stalled frames with a watchdog.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_out,
  output logic       bsy,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int unsigned WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W    = $clog2(PS2_DATA_BITS);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PS2_DATA_BITS - 1);

  logic fall;
  logic bit_s;

  ps2_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_data),
    .fall_o     (fall),
    .data_o     (bit_s)
  );

  ps2_rx_state_t            state_q, state_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     par_q, par_d;
  logic [WD_W-1:0]          wd_q, wd_d;
  logic [7:0]               dout_q, dout_d;
  logic                     bsy_q, bsy_d;
  logic                     valid_q, valid_d;
  logic                     perr_q, perr_d;
  logic                     ferr_q, ferr_d;
  logic                     timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      wd_q    <= '0;
      dout_q  <= '0;
      bsy_q   <= 1'b0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      wd_q    <= wd_d;
      dout_q  <= dout_d;
      bsy_q   <= bsy_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Watchdog saturates at the limit; a timeout overrides any coincident fall.
  assign timeout = (state_q != IDLE) && (wd_q == WD_LIMIT);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    wd_d    = wd_q;
    dout_d  = dout_q;
    bsy_d   = bsy_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;

    if (fall) begin
      wd_d = '0;
    end else if ((state_q != IDLE) && (wd_q != WD_LIMIT)) begin
      wd_d = wd_q + WD_W'(1);
    end

    if (timeout) begin
      state_d = IDLE;
      bsy_d   = 1'b0;
      ferr_d  = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!bit_s) begin
            state_d = DATA;
            cnt_d   = '0;
            bsy_d   = 1'b1;
          end
        end
        DATA: begin
          shift_d[cnt_q] = bit_s;
          cnt_d          = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_d   = bit_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          bsy_d   = 1'b0;
          if (!bit_s) begin
            ferr_d = 1'b1;
          end else if (ps2_odd_parity_ok(shift_q, par_q)) begin
            dout_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign data_out   = dout_q;
  assign bsy        = bsy_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame with an event scoreboard for the result pulses.
`timescale 1ns/1ps
module tb_ps2_rx_frame;

  localparam int unsigned TIMEOUT = 200;
  localparam int unsigned SYNC    = 2;
  localparam int unsigned HALF    = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data_out;
  logic       bsy, valid, parity_err, frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall = 0;
  logic [7:0] model_dout = 8'h00;

  typedef struct {
    int         kind;   // 0 valid, 1 parity error, 2 frame error
    logic [7:0] data;
  } ev_t;
  ev_t exp_q[$];

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data_out   (data_out),
    .bsy        (bsy),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_data_out"}, 32'(data_out), 32'h00);
    chk({tag, "_bsy"}, 32'(bsy), 32'h0);
    chk({tag, "_valid"}, 32'(valid), 32'h0);
    chk({tag, "_parity_err"}, 32'(parity_err), 32'h0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'h0);
  endtask

  task automatic monitor();
    ev_t        e;
    int         kind;
    logic [7:0] dout_prev = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bsy) chk("dout_hold_while_bsy", 32'(data_out), 32'(dout_prev));
        if (valid || parity_err || frame_err) begin
          chk("pulse_exclusive", 32'($onehot0({valid, parity_err, frame_err})), 32'h1);
          kind = valid ? 0 : (parity_err ? 1 : 2);
          chk("event_expected", 32'(exp_q.size() != 0), 32'h1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            if (kind == 0) chk("valid_data", 32'(data_out), 32'(e.data));
          end
        end
      end
      dout_prev = data_out;
    end
  endtask

  // Sends the first n bits of a frame, LSB (start bit) first.
  task automatic send_bits(input logic [10:0] bits, input int n,
                           input logic [7:0] exp_dout, input logic exp_valid);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF / 2) @(negedge clk);
      ps2_clk   = 1'b0;
      last_fall = cyc;
      for (int k = 1; k <= int'(HALF); k++) begin
        @(negedge clk);
        if (i == 0 && k == SYNC + 1) chk("start_bsy_before", 32'(bsy), 32'h0);
        if (i == 0 && k == SYNC + 2) chk("start_bsy_rise", 32'(bsy), 32'h1);
        if (i == 10 && k == SYNC + 1) chk("stop_bsy_before", 32'(bsy), 32'h1);
        if (i == 10 && k == SYNC + 2) begin
          chk("stop_bsy_fall", 32'(bsy), 32'h0);
          chk("stop_data_out", 32'(data_out), 32'(exp_dout));
          chk("stop_valid", 32'(valid), 32'(exp_valid));
        end
      end
      ps2_clk = 1'b1;
      repeat (HALF / 2) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
    ev_t        e;
    logic [7:0] exp_dout = model_dout;
    e.data = data;
    if (!stop)              e.kind = 2;
    else if (^{data, par})  e.kind = 0;
    else                    e.kind = 1;
    if (e.kind == 0) exp_dout = data;
    exp_q.push_back(e);
    send_bits({stop, par, data, 1'b0}, 11, exp_dout, e.kind == 0);
    model_dout = exp_dout;
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  initial begin
    ev_t e;
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    fork
      monitor();
      begin
        #400000;
        $display("FAIL global_timeout: observed no finish, required finish before 400us");
        $fatal(1, "simulation time limit");
      end
    join_none

    repeat (5) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk_idle_outputs("post_reset_idle");

    send_frame(8'h15, 1'b0, 1'b1);
    chk("frame_15", 32'(data_out), 32'h15);

    send_frame(8'hAA, 1'b0, 1'b1);
    chk("bad_parity_keeps", 32'(data_out), 32'h15);
    send_frame(8'hAA, 1'b1, 1'b1);
    chk("frame_aa", 32'(data_out), 32'hAA);

    send_frame(8'h1C, 1'b0, 1'b0);
    chk("bad_stop_keeps", 32'(data_out), 32'hAA);

    e.kind = 2;
    e.data = 8'h00;
    exp_q.push_back(e);
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 4, 8'h00, 1'b0);
    while (!frame_err && (cyc - last_fall) < 400) @(negedge clk);
    chk("timeout_latency", 32'(cyc - last_fall), 32'(SYNC + 2 + TIMEOUT + 1));
    chk("timeout_bsy", 32'(bsy), 32'h0);
    chk("timeout_keeps", 32'(data_out), 32'hAA);
    repeat (HALF) @(negedge clk);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("frame_1c", 32'(data_out), 32'h1C);

    send_bits({1'b1, 1'b0, 8'h15, 1'b0}, 6, 8'h00, 1'b0);
    chk("midframe_bsy", 32'(bsy), 32'h1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("midframe_reset");
    model_dout = 8'h00;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (HALF) @(negedge clk);
    send_frame(8'h15, 1'b0, 1'b1);
    chk("after_reset_15", 32'(data_out), 32'h15);

    repeat (50) @(negedge clk);
    chk("pending_events", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx_frame.md
# ps2_rx_frame

Upstream receive stage of the PS/2 controller. Synchronises the raw PS/2 clock and data lines into the system clock domain, deserialises each 11-bit device-to-host frame, and checks framing and odd parity. Presents the received scan-code byte on `data_out` with a `bsy` qualifier that the downstream busy-gated reader consumes directly.

## Interface
- `TIMEOUT_CYCLES`, default 5000: system clocks without a PS/2 falling edge before an in-progress frame is aborted (100 µs at 50 MHz).
- `SYNC_STAGES`, default 2: flip-flop depth of the input synchronisers; legal values are 2 or more.
- `clk` input, 1 bit: system clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `ps2_clk` input, 1 bit: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data` input, 1 bit: raw PS/2 data pin, asynchronous to `clk`.
- `data_out` output, 8 bits: last good byte; holds its value until the next good frame.
- `bsy` output, 1 bit: high while a frame is being received.
- `valid` output, 1 bit: one-cycle pulse when `data_out` has been updated.
- `parity_err` output, 1 bit: one-cycle pulse when a frame is rejected for bad parity.
- `frame_err` output, 1 bit: one-cycle pulse when a frame is rejected for a bad stop bit or a timeout.

## Operation
- Frame format: start bit (0), then D0..D7 LSB first, then an odd-parity bit, then a stop bit (1).
- Each bit is sampled on a detected falling edge of the synchronised `ps2_clk`.
- Fall detect: the previous synchronised clock was 1 and the current one is 0. The data bit is taken from the synchronised `ps2_data` in the same cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a fall with data=0, go to DATA, clear the 3-bit bit counter, and set `bsy`. On a fall with data=1, ignore it and stay in IDLE with `bsy` low.
  - DATA: on each fall, shift the bit into bit[cnt] of the shift register. When cnt=7, go to PARITY.
  - PARITY: on a fall, latch the parity bit and go to STOP.
  - STOP: on a fall, go to IDLE and clear `bsy`. Then:
    - Stop bit 1 and odd parity holds (XOR of the 8 data bits and the parity bit = 1): load `data_out` and pulse `valid`.
    - Stop bit 1 and parity fails: pulse `parity_err`; `data_out` is unchanged.
    - Stop bit 0: pulse `frame_err` (takes priority over parity); `data_out` is unchanged.
- Watchdog: a counter clears on every fall and increments in any state other than IDLE. When it reaches `TIMEOUT_CYCLES`, go to IDLE, clear `bsy`, and pulse `frame_err`. The counter saturates and does not wrap.
- The watchdog width is `$clog2(TIMEOUT_CYCLES+1)`.
- Reset values: `data_out`=0x00, `bsy`=0, `valid`=0, `parity_err`=0, `frame_err`=0, FSM=IDLE, synchronisers=1 (the PS/2 bus idle level).
- Reset mid-frame discards the partial frame. The next frame is accepted only from a fresh start bit.
- `data_out` never changes while `bsy`=1.

## Timing
- A pin edge reaches fall detection `SYNC_STAGES`+1 clock cycles later (3 with defaults).
- `bsy` rises on the clock after the start-bit fall is detected.
- On a good frame, `valid` and the new `data_out` appear on the clock after the stop-bit fall is detected. `bsy` falls on that same clock.
- Error pulses follow the same timing as `valid`. `valid`, `parity_err` and `frame_err` are mutually exclusive.
- Timeout: `bsy` falls, and `frame_err` pulses, on the clock after the counter reaches `TIMEOUT_CYCLES`.
- If a fall arrives in the same cycle the timeout fires, the timeout wins and the bit is discarded.
- Minimum supported PS/2 clock half-period: 8 system clocks.

## Structure
- Package `ps2_pkg`:
  - `ps2_rx_state_t` enum {IDLE, DATA, PARITY, STOP}.
  - `PS2_DATA_BITS`=8.
  - `PS2_IDLE_LEVEL`=1'b1.
- Sub-module `ps2_sync_edge`: N-stage synchroniser for `ps2_clk` and `ps2_data`, reset to 1, with a registered falling-edge strobe output. It is reusable by the future host-to-device transmit stage.
- Top-level logic: FSM, shift register, parity check, watchdog, output registers.

## Test plan
The bench uses `TIMEOUT_CYCLES`=200 and a PS/2 half-period of 20 clocks.
- Reset: hold `rst_n` low with the pins idle high → all outputs 0 and `bsy` 0; after release, nothing changes while the pins stay high.
- Frame 0x15 with parity 0 and stop 1 → `bsy` high from one clock after the start fall until one clock after the stop fall. Then `data_out`=0x15 with a single `valid` pulse. `data_out` stays 0x00 throughout the frame.
- Frame 0xAA with parity 0 (wrong) → single `parity_err` pulse, no `valid`, `data_out` keeps 0x15. A following 0xAA frame with parity 1 → `data_out`=0xAA.
- Frame 0x1C with stop bit 0 → single `frame_err` pulse, no `valid`, `data_out` unchanged.
- Drive only start+3 bits, then hold `ps2_clk` high → `frame_err` pulse and `bsy` low at 201 clocks after the last fall. The next full 0x1C frame is received correctly.
- Assert `rst_n` after bit D4 of a frame → outputs return to reset values. A 0x15 frame after release is received correctly and gives a single `valid`.
